// File: rtl/gpio_pad_pkg.sv
// Shared types, default parameters and legality helpers for the GPIO pad responder.
// The event struct below matches the default widths; the top re-declares it per instance.
`ifndef GPIO_DATA_WIDTH
`define GPIO_DATA_WIDTH 8
`endif

package gpio_pad_pkg;

  localparam int GPIO_PAD_DW_DEF         = `GPIO_DATA_WIDTH;
  localparam int GPIO_PAD_DELAY_DEF      = 2;
  localparam int GPIO_PAD_CONT_DEF       = 3;
  localparam int GPIO_PAD_TS_W_DEF       = 16;
  localparam int GPIO_PAD_FIFO_DEPTH_DEF = 8;

  localparam int GPIO_PAD_DELAY_MIN = 1;
  localparam int GPIO_PAD_DELAY_MAX = 4;
  localparam int GPIO_PAD_CONT_MIN  = 1;
  localparam int GPIO_PAD_CONT_MAX  = 15;

  typedef struct packed {
    logic [GPIO_PAD_DW_DEF-1:0]   pins;
    logic [GPIO_PAD_TS_W_DEF-1:0] stamp;
  } gpio_pad_evt_t;

  function automatic bit pad_delay_ok(int d);
    return (d >= GPIO_PAD_DELAY_MIN) && (d <= GPIO_PAD_DELAY_MAX);
  endfunction

  function automatic bit cont_cycles_ok(int c);
    return (c >= GPIO_PAD_CONT_MIN) && (c <= GPIO_PAD_CONT_MAX);
  endfunction

  function automatic bit fifo_depth_ok(int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/gpio_pad_evt_fifo.sv
// Show-ahead synchronous FIFO for pad events; head reads as zero while empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module gpio_pad_evt_fifo
  import gpio_pad_pkg::*;
#(
  parameter int  DEPTH = GPIO_PAD_FIFO_DEPTH_DEF,
  parameter type evt_t = gpio_pad_evt_t
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic push_i,
  input  evt_t push_data_i,
  input  logic pop_i,
  output evt_t head_o,
  output logic empty_o,
  output logic full_o
);

  localparam int AW = $clog2(DEPTH);

  evt_t          mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  assign head_o = empty_o ? evt_t'('0) : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/gpio_pad_responder.sv
// Pad-side model of the GPIO block: resolves each pad, returns it through a delay
// pipeline, flags drive contention and logs timestamped pad changes in a FIFO.
module gpio_pad_responder
  import gpio_pad_pkg::*;
#(
  parameter int          DW          = `GPIO_DATA_WIDTH,
  parameter int          PAD_DELAY   = GPIO_PAD_DELAY_DEF,
  parameter logic [DW-1:0] PULL_VAL  = '0,
  parameter int          CONT_CYCLES = GPIO_PAD_CONT_DEF,
  parameter int          TS_W        = GPIO_PAD_TS_W_DEF,
  parameter int          FIFO_DEPTH  = GPIO_PAD_FIFO_DEPTH_DEF
) (
  input  logic            pclk,
  input  logic            n_p_reset,
  input  logic [DW-1:0]   n_gpio_pin_oe,
  input  logic [DW-1:0]   gpio_pin_out,
  output logic [DW-1:0]   gpio_pin_in,
  input  logic [DW-1:0]   ext_drive_en,
  input  logic [DW-1:0]   ext_value,
  input  logic [DW-1:0]   clr_contention,
  output logic [DW-1:0]   contention,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [DW-1:0]   evt_pins,
  output logic [TS_W-1:0] evt_time,
  input  logic            clr_overflow,
  output logic            evt_overflow
);

  if (!pad_delay_ok(PAD_DELAY)) begin : g_bad_pad_delay
    $error("gpio_pad_responder: PAD_DELAY must be within 1..4");
  end
  if (!cont_cycles_ok(CONT_CYCLES)) begin : g_bad_cont_cycles
    $error("gpio_pad_responder: CONT_CYCLES must be within 1..15");
  end
  if (!fifo_depth_ok(FIFO_DEPTH)) begin : g_bad_fifo_depth
    $error("gpio_pad_responder: FIFO_DEPTH must be a power of 2, at least 2");
  end

  typedef struct packed {
    logic [DW-1:0]   pins;
    logic [TS_W-1:0] stamp;
  } evt_t;

  localparam logic [3:0] CONT_MAX = 4'(CONT_CYCLES);

  logic [DW-1:0]   pad;
  logic [DW-1:0]   contend;
  logic [DW-1:0]   pipe_q [PAD_DELAY];
  logic [DW-1:0]   pad_q;
  logic [3:0]      cnt_q [DW];
  logic [3:0]      cnt_d [DW];
  logic [DW-1:0]   cont_flag_q, cont_flag_d;
  logic [TS_W-1:0] ts_q;
  logic            ovf_q, ovf_d;
  logic            evt_push, evt_pop, evt_drop;
  logic            fifo_full, fifo_empty;
  evt_t            evt_in, evt_head;

  // GPIO output enable has priority, then the external driver, then the pull.
  assign pad = (~n_gpio_pin_oe & gpio_pin_out) |
               ( n_gpio_pin_oe &  ext_drive_en & ext_value) |
               ( n_gpio_pin_oe & ~ext_drive_en & PULL_VAL);

  assign contend = ~n_gpio_pin_oe & ext_drive_en & (gpio_pin_out ^ ext_value);

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      for (int s = 0; s < PAD_DELAY; s++) pipe_q[s] <= PULL_VAL;
      pad_q <= PULL_VAL;
      ts_q  <= '0;
    end else begin
      pipe_q[0] <= pad;
      for (int s = 1; s < PAD_DELAY; s++) pipe_q[s] <= pipe_q[s-1];
      pad_q <= pad;
      ts_q  <= ts_q + 1'b1;
    end
  end

  // Holding the counter at CONT_MAX keeps the set term active, so a clear
  // cannot drop the flag while contention persists.
  always_comb begin
    cont_flag_d = cont_flag_q;
    for (int i = 0; i < DW; i++) begin
      cnt_d[i] = '0;
      if (contend[i]) begin
        cnt_d[i] = (cnt_q[i] >= CONT_MAX) ? CONT_MAX : cnt_q[i] + 4'd1;
      end
      cont_flag_d[i] = (cnt_d[i] == CONT_MAX) || (cont_flag_q[i] && !clr_contention[i]);
    end
  end

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      for (int i = 0; i < DW; i++) cnt_q[i] <= '0;
      cont_flag_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      for (int i = 0; i < DW; i++) cnt_q[i] <= cnt_d[i];
      cont_flag_q <= cont_flag_d;
      ovf_q       <= ovf_d;
    end
  end

  assign evt_push     = (pad != pad_q);
  assign evt_pop      = evt_valid && evt_ready;
  assign evt_drop     = evt_push && fifo_full && !evt_pop;
  assign ovf_d        = evt_drop || (ovf_q && !clr_overflow);
  assign evt_in.pins  = pad;
  assign evt_in.stamp = ts_q;

  gpio_pad_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .evt_t (evt_t)
  ) u_evt_fifo (
    .clk_i       (pclk),
    .rst_n_i     (n_p_reset),
    .push_i      (evt_push),
    .push_data_i (evt_in),
    .pop_i       (evt_pop),
    .head_o      (evt_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign gpio_pin_in  = pipe_q[PAD_DELAY-1];
  assign contention   = cont_flag_q;
  assign evt_valid    = !fifo_empty;
  assign evt_pins     = evt_head.pins;
  assign evt_time     = evt_head.stamp;
  assign evt_overflow = ovf_q;

endmodule

// File: doc/gpio_pad_responder.md
# gpio_pad_responder

Pad-side counterpart of the GPIO block. It consumes `gpio_pin_out` and `n_gpio_pin_oe` from the GPIO block, resolves each pad against an external driver and a pull value, and returns the result on `gpio_pin_in` through a programmable pad-delay pipeline. It also flags drive contention and records pad value changes with timestamps in a small event FIFO. It sits between the GPIO RTL and the testbench or top-level pad ring.

## Interface
- `DW`, default `` `GPIO_DATA_WIDTH ``: pin count.
- `PAD_DELAY`, default 2: registered stages from pad to `gpio_pin_in`; legal range 1..4.
- `PULL_VAL`, default all-zeros: value of an undriven pad, per pin.
- `CONT_CYCLES`, default 3: consecutive contention cycles needed to set the sticky flag; legal range 1..15.
- `TS_W`, default 16: timestamp width.
- `FIFO_DEPTH`, default 8: event FIFO entries; must be a power of 2.
- `pclk` in 1: clock.
- `n_p_reset` in 1: reset, asynchronous and active-low.
- `n_gpio_pin_oe` in DW: per-pin output enable, active-low.
- `gpio_pin_out` in DW: value driven by the GPIO block.
- `gpio_pin_in` out DW: resolved pad value, delayed.
- `ext_drive_en` in DW: external driver enable, per pin.
- `ext_value` in DW: external driver value.
- `clr_contention` in DW: clear for the sticky contention flags.
- `contention` out DW: sticky contention flag, per pin.
- `evt_valid` out 1: FIFO non-empty.
- `evt_ready` in 1: pop request.
- `evt_pins` out DW: pad value of the head entry.
- `evt_time` out TS_W: timestamp of the head entry.
- `clr_overflow` in 1: clear for `evt_overflow`.
- `evt_overflow` out 1: sticky flag, set when an event is dropped.

## Operation
- Pad resolve (combinational), per pin i:
  - `pad[i] = !n_gpio_pin_oe[i] ? gpio_pin_out[i] : ext_drive_en[i] ? ext_value[i] : PULL_VAL[i]`.
  - The GPIO block wins the pad whenever its output enable is active.
- Delay pipeline:
  - `pad` enters a PAD_DELAY-deep shift register.
  - `gpio_pin_in` is the last stage.
- Contention detection, per pin:
  - Contention is a cycle with `!n_gpio_pin_oe[i] && ext_drive_en[i] && gpio_pin_out[i] != ext_value[i]`.
  - A 4-bit counter increments on each contention cycle, saturating at CONT_CYCLES.
  - The counter clears on any non-contention cycle.
  - When the counter reaches CONT_CYCLES, `contention[i]` sets.
  - `clr_contention[i]` clears the flag. If set and clear occur in the same cycle, set wins.
- Timestamp: free-running TS_W counter, increments every cycle, wraps from all-ones to 0.
- Event recording:
  - `pad_q` holds the previous cycle's `pad`.
  - When `pad != pad_q`, the block pushes `{pad, ts}`, where `ts` is the counter value in that cycle.
  - Changes on several pins in the same cycle produce a single event.
- FIFO behaviour:
  - Show-ahead: `evt_pins`/`evt_time` are valid whenever `evt_valid` is high.
  - Pop occurs when `evt_valid && evt_ready`.
  - Push while full and not popping: the event is dropped and `evt_overflow` sets.
  - Push and pop in the same cycle while full: both succeed and nothing is dropped.
  - Push and pop in the same cycle while empty: no bypass. The entry becomes visible next cycle.
  - `clr_overflow` clears `evt_overflow`. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values:
  - `gpio_pin_in` = PULL_VAL (all pipeline stages).
  - `pad_q` = PULL_VAL.
  - `contention` = 0; counters = 0.
  - `ts` = 0.
  - FIFO empty, so `evt_valid` = 0; `evt_pins`/`evt_time` = 0.
  - `evt_overflow` = 0.
- No spurious event after reset when the pad equals PULL_VAL.
- Latency:
  - A pad change at edge N appears on `gpio_pin_in` after edge N+PAD_DELAY.
  - `evt_valid` rises one cycle after the change cycle.
- Contention flag: sets on the edge ending the CONT_CYCLES-th consecutive contention cycle.
- Timestamp wrap is not flagged. Software handles modular differences.
- Reset asserted mid-operation: all state returns to reset values asynchronously and queued events are lost. Deassertion is synchronised externally.

## Structure
- Package `gpio_pad_pkg` holds:
  - `gpio_pad_evt_t` struct: pins, time.
  - Default-parameter localparams.
  - The PAD_DELAY range-check constant.
- Sub-module `gpio_pad_evt_fifo`: parameterised synchronous FIFO of `gpio_pad_evt_t`, with full/empty flags and show-ahead output.
- The top level holds the pad resolve, delay pipeline, contention counters and timestamp.
- Elaboration-time assertion on parameter legality.

## Test plan
- Reset with `PULL_VAL=0`, no drivers -> `gpio_pin_in=0`, `evt_valid=0` for 20 cycles.
- Pin 3: `n_gpio_pin_oe[3]=0`, `gpio_pin_out[3]` 0->1 at cycle 10 -> `gpio_pin_in[3]=1` from cycle 12 (PAD_DELAY=2); one event with `pins=0x8`, `time=10`.
- Pin 0: oe active, out=1, `ext_drive_en=1`, `ext_value=0`:
  - Held 2 cycles -> `contention[0]` stays 0.
  - Held 3 cycles -> `contention[0]` sets.
  - `clr_contention[0]` coincident with a further contention cycle -> flag remains 1.
- 9 toggles of `ext_value[1]` with oe inactive, `evt_ready=0` -> 8 entries, `evt_overflow=1`. Then pop all with `evt_ready=1` -> timestamps strictly increasing, ninth event absent.
- FIFO full with push and pop in the same cycle -> no overflow, occupancy stays 8.
- Assert `n_p_reset` mid-burst with 5 queued events -> `evt_valid=0`, `contention=0` and `gpio_pin_in=PULL_VAL` immediately, without waiting for a clock edge.
